// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data-memory port with req/ack handshake and byte lanes
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS data-memory stage: legality check, byte lanes, stall, load extension
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemRead_i,
    input  logic                    MemWrite_i,
    input  logic [1:0]              size_i,
    input  logic                    is_unsigned_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_out_o,
    output logic                    stall_o,
    output logic                    err_o,
    load_store_unit_if.master       mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        abort_q, abort_d;

    logic        access;
    logic        illegal;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [3:0]  be_sel;
    logic [31:0] wdata_rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end
    end

    // Lane steering and load extension work off the latched request only.
    always_comb begin
        shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = mem.mem_rdata;
        endcase
        case (size_q)
            SZ_BYTE: begin
                be_sel    = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_sel    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be_sel    = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign access  = MemRead_i | MemWrite_i;
    assign illegal = (size_i == 2'b11)
                   | ((size_i == SZ_HALF) & addr_i[0])
                   | ((size_i == SZ_WORD) & (addr_i[1:0] != 2'b00))
                   | (MemRead_i & MemWrite_i);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        addr_d         = addr_q;
        size_d         = size_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        uns_d          = uns_q;
        rdata_d        = rdata_q;
        abort_d        = abort_q;
        stall_o        = 1'b0;
        err_o          = 1'b0;
        rdata_out_o    = '0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_be     = '0;
        mem.mem_wdata  = '0;
        // Outputs are forced low while reset is held, even with a request pending.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    abort_d = 1'b0;
                    if (access) begin
                        if (illegal) begin
                            err_o = 1'b1;
                        end else begin
                            stall_o = 1'b1;
                            addr_d  = addr_i;
                            size_d  = size_i;
                            wdata_d = wdata_i;
                            we_d    = MemWrite_i;
                            uns_d   = is_unsigned_i;
                            rdata_d = '0;
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    stall_o       = 1'b1;
                    mem.mem_req   = 1'b1;
                    mem.mem_we    = we_q;
                    mem.mem_addr  = {addr_q[31:2], 2'b00};
                    mem.mem_be    = be_sel;
                    mem.mem_wdata = wdata_rep;
                    count_d       = count_q + 8'd1;
                    // An ack on the final allowed cycle still wins over the abort.
                    if (mem.mem_ack) begin
                        if (!we_q) rdata_d = load_ext;
                        state_d = DONE;
                    end else if (count_q == LAST_CNT) begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    err_o       = abort_q;
                    rdata_out_o = rdata_q;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        is_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_out;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead_i     (MemRead),
        .MemWrite_i    (MemWrite),
        .size_i        (size),
        .is_unsigned_i (is_unsigned),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rdata_out_o   (rdata_out),
        .stall_o       (stall),
        .err_o         (err),
        .mem           (mem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          n_stall;
        int          n_req;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] md, input int ack_dly, input exp_t e);
        int   n_stall;
        int   n_req;
        bit   done;
        exp_t got;
        n_stall = 0;
        n_req   = 0;
        done    = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; size = sz; is_unsigned = uns; addr = a; wdata = wd;
        exp_q.push_back(e);
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_if.mem_ack = 1'b0;
            if (stall) n_stall++;
            if (mem_if.mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    check({tag, " mem_addr"},  mem_if.mem_addr,  exp_q[0].addr);
                    check({tag, " mem_be"},    {28'd0, mem_if.mem_be}, {28'd0, exp_q[0].be});
                    check({tag, " mem_wdata"}, mem_if.mem_wdata, exp_q[0].wdata);
                    check({tag, " mem_we"},    {31'd0, mem_if.mem_we}, {31'd0, exp_q[0].we});
                end
                if (ack_dly >= 0 && n_req == ack_dly + 1) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = md;
                end
            end
            if (!stall) begin
                got = exp_q.pop_front();
                check({tag, " rdata_out"}, rdata_out, got.rdata);
                check({tag, " err"},       {31'd0, err}, {31'd0, got.err});
                check({tag, " stall_cycles"}, n_stall, got.n_stall);
                check({tag, " req_cycles"},   n_req,   got.n_req);
                MemRead = 1'b0; MemWrite = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            check({tag, " completion_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            MemRead = 1'b0; MemWrite = 1'b0; mem_if.mem_ack = 1'b0;
        end
        @(negedge clk);
        #1;
        check({tag, " err_after"},   {31'd0, err},   32'd0);
        check({tag, " stall_after"}, {31'd0, stall}, 32'd0);
        check({tag, " rdata_after"}, rdata_out,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        #12;
        check("reset mem_req",   {31'd0, mem_if.mem_req}, 32'd0);
        check("reset stall",     {31'd0, stall},          32'd0);
        check("reset err",       {31'd0, err},            32'd0);
        check("reset rdata_out", rdata_out,               32'd0);
        check("reset mem_addr",  mem_if.mem_addr,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addr, be, wdata, we, rdata, err, n_stall, n_req
        access("lw",  1, 0, 2'b10, 0, 32'h104, 32'h0, 32'hDEADBEEF, 0,
               '{32'h104, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1});
        access("lb",  1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0,
               '{32'h100, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 2, 1});
        access("lbu", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0,
               '{32'h100, 4'b1000, 32'h0, 1'b0, 32'h00000080, 1'b0, 2, 1});
        access("lh",  1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80112233, 1,
               '{32'h100, 4'b1100, 32'h0, 1'b0, 32'hFFFF8011, 1'b0, 3, 2});
        access("lhu", 1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h8011A233, 0,
               '{32'h100, 4'b0011, 32'h0, 1'b0, 32'h0000A233, 1'b0, 2, 1});
        access("sh",  0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h12345678, 0,
               '{32'h20, 4'b1100, 32'hABCDABCD, 1'b1, 32'h0, 1'b0, 2, 1});
        access("sb",  0, 1, 2'b00, 0, 32'h101, 32'h1234565A, 32'h0, 2,
               '{32'h100, 4'b0010, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, 4, 3});
        access("lw_misaligned", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0,
               '{32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0});
        access("sh_misaligned", 0, 1, 2'b01, 0, 32'h21, 32'hABCD, 32'h0, 0,
               '{32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0});
        access("size_illegal", 1, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0,
               '{32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0});
        access("rd_and_wr", 1, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 0,
               '{32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 0, 0});
        access("sw_timeout", 0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, -1,
               '{32'h40, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 5, 4});

        // Reset pulse in the middle of an outstanding load.
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; size = 2'b10; is_unsigned = 1'b0; addr = 32'h200;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst mem_req", {31'd0, mem_if.mem_req}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst mem_req",   {31'd0, mem_if.mem_req}, 32'd0);
        check("rst stall",     {31'd0, stall},          32'd0);
        check("rst err",       {31'd0, err},            32'd0);
        check("rst rdata_out", rdata_out,               32'd0);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        access("lw_after_rst", 1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h01234567, 3,
               '{32'h200, 4'b1111, 32'h0, 1'b0, 32'h01234567, 1'b0, 5, 4});

        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
